// File: rtl/maxpool_stage.sv
// maxpool_stage: 2x2 non-overlapping max pooling of a layer-0 map into layer-1.
// The map is read through a shared 1-cycle-latency read port and written back
// through a write port. csel selects the memory bank for each access.
module maxpool_stage #(
  parameter int         DW      = 20,
  parameter int         AW      = 12,
  parameter int         IMG_W   = 64,
  parameter logic [2:0] SRC_SEL = 3'b001,
  parameter logic [2:0] DST_SEL = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int HW = IMG_W / 2;
  localparam int CW = (HW > 1) ? $clog2(HW) : 1;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, WR, FIN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] r_reg, r_next;
  logic [CW-1:0] c_reg, c_next;
  logic [DW-1:0] v_reg  [0:2];
  logic [DW-1:0] v_next [0:2];

  logic          busy_next, done_next, crd_next, cwr_next;
  logic [2:0]    csel_next;
  logic [AW-1:0] caddr_rd_next, caddr_wr_next;
  logic [DW-1:0] cdata_wr_next;

  // Source address of element k (0..3, row-major) inside window (r, c).
  function automatic logic [AW-1:0] rd_addr(input logic [CW-1:0] r,
                                            input logic [CW-1:0] c,
                                            input logic [1:0]    k);
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    row = AW'({r, k[1]});
    col = AW'({c, k[0]});
    return (row * AW'(IMG_W)) + col;
  endfunction

  // Signed maximum; the incumbent a is kept on a tie.
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

  // State, window counters, captured samples and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      c_reg     <= '0;
      for (int i = 0; i < 3; i++) v_reg[i] <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crd       <= 1'b0;
      cwr       <= 1'b0;
      csel      <= 3'b000;
      caddr_rd  <= '0;
      caddr_wr  <= '0;
      cdata_wr  <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      v_reg     <= v_next;
      busy      <= busy_next;
      done      <= done_next;
      crd       <= crd_next;
      cwr       <= cwr_next;
      csel      <= csel_next;
      caddr_rd  <= caddr_rd_next;
      caddr_wr  <= caddr_wr_next;
      cdata_wr  <= cdata_wr_next;
    end
  end

  // Next state and next output values; strobes default low, addresses hold.
  always_comb begin
    state_next    = state_reg;
    r_next        = r_reg;
    c_next        = c_reg;
    v_next        = v_reg;
    busy_next     = busy;
    done_next     = 1'b0;
    crd_next      = 1'b0;
    cwr_next      = 1'b0;
    csel_next     = 3'b000;
    caddr_rd_next = caddr_rd;
    caddr_wr_next = caddr_wr;
    cdata_wr_next = cdata_wr;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = RD0;
          busy_next     = 1'b1;
          r_next        = '0;
          c_next        = '0;
          crd_next      = 1'b1;
          csel_next     = SRC_SEL;
          caddr_rd_next = rd_addr('0, '0, 2'd0);
        end
      end
      RD0: begin
        state_next    = RD1;
        crd_next      = 1'b1;
        csel_next     = SRC_SEL;
        caddr_rd_next = rd_addr(r_reg, c_reg, 2'd1);
      end
      RD1: begin
        state_next    = RD2;
        v_next[0]     = cdata_rd;
        crd_next      = 1'b1;
        csel_next     = SRC_SEL;
        caddr_rd_next = rd_addr(r_reg, c_reg, 2'd2);
      end
      RD2: begin
        state_next    = RD3;
        v_next[1]     = cdata_rd;
        crd_next      = 1'b1;
        csel_next     = SRC_SEL;
        caddr_rd_next = rd_addr(r_reg, c_reg, 2'd3);
      end
      RD3: begin
        // Last read is in flight; its data arrives during CAP.
        state_next = CAP;
        v_next[2]  = cdata_rd;
      end
      CAP: begin
        state_next    = WR;
        cwr_next      = 1'b1;
        csel_next     = DST_SEL;
        caddr_wr_next = (AW'(r_reg) * AW'(HW)) + AW'(c_reg);
        cdata_wr_next = max2(max2(max2(v_reg[0], v_reg[1]), v_reg[2]), cdata_rd);
      end
      WR: begin
        c_next = c_reg + 1'b1;
        if (c_reg == CW'(HW - 1)) r_next = r_reg + 1'b1;
        if ((r_reg == CW'(HW - 1)) && (c_reg == CW'(HW - 1))) begin
          state_next = FIN;
        end else begin
          state_next    = RD0;
          crd_next      = 1'b1;
          csel_next     = SRC_SEL;
          caddr_rd_next = rd_addr(r_next, c_next, 2'd0);
        end
      end
      FIN: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_maxpool_stage.sv
// tb_maxpool_stage: directed passes over hand-built layer-0 maps; expected
// layer-1 writes are queued per pass and checked by an independent monitor.
module tb_maxpool_stage;

  localparam int         DW  = 20;
  localparam int         AW  = 12;
  localparam logic [2:0] SRC = 3'b001;
  localparam logic [2:0] DST = 3'b011;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] l0 [0:4095];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int viol     = 0;

  always #5 clk = ~clk;

  maxpool_stage dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Layer-0 memory: registered read, one cycle of latency.
  always @(posedge clk) begin
    if (crd) cdata_rd <= l0[caddr_rd];
  end

  // Monitor: protocol rules, access counts and scoreboard comparison of writes.
  always @(negedge clk) begin
    if (!reset) begin
      if (crd) begin
        rd_cnt++;
        if (csel !== SRC) viol++;
      end
      if (cwr) begin
        wr_cnt++;
        if (csel !== DST) viol++;
        if (crd) viol++;
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=0x%0h data=0x%0h expected=none", caddr_wr, cdata_wr);
        end else begin
          chk("wr_addr", 32'(caddr_wr), 32'(exp_addr.pop_front()));
          chk("wr_data", 32'(cdata_wr), 32'(exp_data.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_ramp();
    for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
  endtask

  // Expected output for a ramp map: the bottom-right element of each window.
  task automatic push_ramp_expect();
    for (int w = 0; w < 1024; w++) begin
      exp_addr.push_back(AW'(w));
      exp_data.push_back(DW'((2 * (w / 32) + 1) * 64 + 2 * (w % 32) + 1));
    end
  endtask

  task automatic run_pass(input string name, input bit check_lat, input bit busy_pulses);
    int n;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; viol = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 7000) begin
      @(posedge clk);
      n++;
      #1;
      start = (busy_pulses && busy && (n % 1000 == 500)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    if (check_lat) chk({name, "_latency"}, 32'(n), 32'd6145);
    repeat (3) @(negedge clk);
    chk({name, "_reads"}, 32'(rd_cnt), 32'd4096);
    chk({name, "_writes"}, 32'(wr_cnt), 32'd1024);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_protocol_violations"}, 32'(viol), 32'd0);
    chk({name, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    $display("pass %s: cycles=%0d reads=%0d writes=%0d dones=%0d", name, n, rd_cnt, wr_cnt, done_cnt);
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    int rd_saved, wr_saved;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_crd", 32'(crd), 32'd0);
    chk("rst_cwr", 32'(cwr), 32'd0);
    chk("rst_csel", 32'(csel), 32'd0);
    chk("rst_caddr_rd", 32'(caddr_rd), 32'd0);
    chk("rst_caddr_wr", 32'(caddr_wr), 32'd0);
    chk("rst_cdata_wr", 32'(cdata_wr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a pass aborts it.
    load_ramp();
    push_ramp_expect();
    rd_cnt = 0; wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_crd", 32'(crd), 32'd0);
    chk("abort_cwr", 32'(cwr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_saved = rd_cnt;
    wr_saved = wr_cnt;
    repeat (50) @(negedge clk);
    chk("abort_no_reads", 32'(rd_cnt), 32'(rd_saved));
    chk("abort_no_writes", 32'(wr_cnt), 32'(wr_saved));
    chk("abort_idle", 32'(busy), 32'd0);
    $display("pass abort: reads=%0d writes=%0d before reset", rd_saved, wr_saved);
    exp_addr.delete();
    exp_data.delete();

    // Full ramp pass after the abort, with latency check.
    load_ramp();
    push_ramp_expect();
    run_pass("ramp", 1'b1, 1'b0);

    // Maximum in each of the four window positions, including the row wrap.
    load_ramp();
    l0[0]   = 20'd9; l0[1]   = 20'd1; l0[64]  = 20'd1; l0[65]  = 20'd1;
    l0[2]   = 20'd1; l0[3]   = 20'd9; l0[66]  = 20'd1; l0[67]  = 20'd1;
    l0[128] = 20'd1; l0[129] = 20'd1; l0[192] = 20'd9; l0[193] = 20'd1;
    l0[130] = 20'd1; l0[131] = 20'd1; l0[194] = 20'd1; l0[195] = 20'd9;
    push_ramp_expect();
    exp_data[0]  = 20'd9;
    exp_data[1]  = 20'd9;
    exp_data[32] = 20'd9;
    exp_data[33] = 20'd9;
    run_pass("position", 1'b0, 1'b0);

    // Signed compare, ties, all-negative last window; start pulses while busy.
    load_ramp();
    l0[0]    = 20'hFFFFF; l0[1]    = 20'h80000; l0[64]   = 20'h00000; l0[65]   = 20'hFFFFF;
    l0[2]    = 20'h12345; l0[3]    = 20'h12345; l0[66]   = 20'h12345; l0[67]   = 20'h12345;
    l0[4030] = 20'h80000; l0[4031] = 20'h80001; l0[4094] = 20'hFFFFE; l0[4095] = 20'hFFFFD;
    push_ramp_expect();
    exp_data[0]    = 20'h00000;
    exp_data[1]    = 20'h12345;
    exp_data[1023] = 20'hFFFFE;
    run_pass("signed", 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
